cmd_turnaround_tracker: RTL and testbench



---
 rtl/mc_turnaround_pkg.sv | 25 ++
 rtl/turnaround_down_counter.sv | 41 ++++
 rtl/cmd_turnaround_tracker.sv | 156 +++++++++++++++
 tb/tb_cmd_turnaround_tracker.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_turnaround_pkg.sv
// Shared types and default timing for the channel turnaround tracker.
package mc_turnaround_pkg;

    typedef enum logic {
        CMD_RD,
        CMD_WR
    } cmd_kind_e;

    typedef enum logic [1:0] {
        TS_IDLE,
        TS_LAST_RD,
        TS_LAST_WR
    } turn_state_e;

    localparam int DEF_NUM_RANK = 4;
    localparam int DEF_T_RTRS   = 2;
    localparam int DEF_T_RTW    = 4;
    localparam int DEF_T_WTR    = 6;

    // Counter width able to hold T-1; never narrower than one bit.
    function automatic int cnt_width(input int t);
        return (t < 2) ? 1 : $clog2(t);
    endfunction

endpackage

// File: rtl/turnaround_down_counter.sv
// Loadable saturating down-counter; busy while the count is nonzero.
// A load of T-1 at cycle N keeps busy high for cycles N+1 .. N+T-1.
module turnaround_down_counter
    import mc_turnaround_pkg::*;
#(
    parameter int T = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);

    localparam int W = cnt_width(T);
    localparam logic [W-1:0] LOAD_VAL = W'(T - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over decrement; an idle counter rests at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/cmd_turnaround_tracker.sv
// Channel-wide CMD turnaround tracker: rank-to-rank (tRTRS), read-to-write
// (tRTW) and same-rank write-to-read (tWTR). Publishes per-rank read/write
// issue masks computed only from flops, and a sticky protocol error flag.
// Optional statistics counters are built when TURNAROUND_STATS_EN is defined.
//
// Handshake: issue_valid is a one-cycle report of a command already issued by
// the scheduler; there is no ready, every reported issue is recorded.
module cmd_turnaround_tracker
    import mc_turnaround_pkg::*;
#(
    parameter int NUM_RANK = DEF_NUM_RANK,
    parameter int T_RTRS   = DEF_T_RTRS,
    parameter int T_RTW    = DEF_T_RTW,
    parameter int T_WTR    = DEF_T_WTR,
    parameter int RANK_W   = (NUM_RANK > 1) ? $clog2(NUM_RANK) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [RANK_W-1:0]   issue_rank,
    input  logic                issue_is_wr,
    output logic [NUM_RANK-1:0] rd_free,
    output logic [NUM_RANK-1:0] wr_free,
    output logic                turnaround_free,
    output logic                protocol_err,
    output turn_state_e         dbg_state
`ifdef TURNAROUND_STATS_EN
    ,
    output logic [15:0]         stat_rank_switch,
    output logic [15:0]         stat_rw_switch
`endif
);

    turn_state_e       state_q, state_d;
    logic [RANK_W-1:0] last_rank_q, last_rank_d;
    logic              err_q, err_d;

    logic      rtrs_busy, rtw_busy, wtr_busy;
    logic      issue_ok;
    cmd_kind_e issue_kind;

    assign issue_kind = issue_is_wr ? CMD_WR : CMD_RD;

    turnaround_down_counter #(.T(T_RTRS)) u_cnt_rtrs (
        .clk  (clk),
        .rst  (rst),
        .load (issue_valid),
        .busy (rtrs_busy)
    );

    turnaround_down_counter #(.T(T_RTW)) u_cnt_rtw (
        .clk  (clk),
        .rst  (rst),
        .load (issue_valid && (issue_kind == CMD_RD)),
        .busy (rtw_busy)
    );

    turnaround_down_counter #(.T(T_WTR)) u_cnt_wtr (
        .clk  (clk),
        .rst  (rst),
        .load (issue_valid && (issue_kind == CMD_WR)),
        .busy (wtr_busy)
    );

    // Permission masks derived purely from registered state.
    always_comb begin
        rd_free = '0;
        wr_free = '0;
        for (int r = 0; r < NUM_RANK; r++) begin
            logic other_rank;
            logic rtrs_blk;
            other_rank = (RANK_W'(r) != last_rank_q);
            rtrs_blk   = rtrs_busy && other_rank && (state_q != TS_IDLE);
            rd_free[r] = !rtrs_blk && !(wtr_busy && !other_rank);
            wr_free[r] = !rtrs_blk && !rtw_busy;
        end
        turnaround_free = !(rtrs_busy || rtw_busy || wtr_busy);
    end

    // Legality of the reported issue; out-of-range ranks never match.
    always_comb begin
        issue_ok = 1'b0;
        for (int r = 0; r < NUM_RANK; r++) begin
            if (issue_rank == RANK_W'(r)) begin
                issue_ok = (issue_kind == CMD_WR) ? wr_free[r] : rd_free[r];
            end
        end
    end

    // Last-type FSM, last rank capture and sticky error next-state.
    always_comb begin
        state_d     = state_q;
        last_rank_d = last_rank_q;
        err_d       = err_q;
        if (issue_valid) begin
            state_d     = (issue_kind == CMD_WR) ? TS_LAST_WR : TS_LAST_RD;
            last_rank_d = issue_rank;
            if (!issue_ok) begin
                err_d = 1'b1;
            end
        end
    end

    // Tracker state registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= TS_IDLE;
            last_rank_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_rank_q <= last_rank_d;
            err_q       <= err_d;
        end
    end

    assign protocol_err = err_q;
    assign dbg_state    = state_q;

`ifdef TURNAROUND_STATS_EN
    logic [15:0] rank_sw_q, rank_sw_d;
    logic [15:0] rw_sw_q, rw_sw_d;

    // Saturating counts of rank changes and read/write direction changes.
    always_comb begin
        rank_sw_d = rank_sw_q;
        rw_sw_d   = rw_sw_q;
        if (issue_valid) begin
            if ((state_q != TS_IDLE) && (issue_rank != last_rank_q) &&
                (rank_sw_q != 16'hFFFF)) begin
                rank_sw_d = rank_sw_q + 16'd1;
            end
            if ((((state_q == TS_LAST_RD) && (issue_kind == CMD_WR)) ||
                 ((state_q == TS_LAST_WR) && (issue_kind == CMD_RD))) &&
                (rw_sw_q != 16'hFFFF)) begin
                rw_sw_d = rw_sw_q + 16'd1;
            end
        end
    end

    // Statistics registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rank_sw_q <= '0;
            rw_sw_q   <= '0;
        end else begin
            rank_sw_q <= rank_sw_d;
            rw_sw_q   <= rw_sw_d;
        end
    end

    assign stat_rank_switch = rank_sw_q;
    assign stat_rw_switch   = rw_sw_q;
`endif

endmodule

// File: tb/tb_cmd_turnaround_tracker.sv
// Directed bench for cmd_turnaround_tracker at default parameters.
module tb_cmd_turnaround_tracker;
    import mc_turnaround_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic [1:0]  issue_rank = 2'd0;
    logic        issue_is_wr = 1'b0;
    logic [3:0]  rd_free;
    logic [3:0]  wr_free;
    logic        turnaround_free;
    logic        protocol_err;
    turn_state_e dbg_state;
`ifdef TURNAROUND_STATS_EN
    logic [15:0] stat_rank_switch;
    logic [15:0] stat_rw_switch;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Expected {turnaround_free, rd_free, wr_free} per cycle.
    logic [8:0] exp_q[$];
    logic [8:0] exp_v;

    cmd_turnaround_tracker dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_rank      (issue_rank),
        .issue_is_wr     (issue_is_wr),
        .rd_free         (rd_free),
        .wr_free         (wr_free),
        .turnaround_free (turnaround_free),
        .protocol_err    (protocol_err),
        .dbg_state       (dbg_state)
`ifdef TURNAROUND_STATS_EN
        ,
        .stat_rank_switch(stat_rank_switch),
        .stat_rw_switch  (stat_rw_switch)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Drivers: inputs change and outputs are sampled 1 time unit after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        issue_valid = 1'b0;
        rst = 1'b0;
        ticks(2);
        rst = 1'b1;
    endtask

    // Issue at the current cycle N; returns in cycle N+1.
    task automatic issue_cmd(input logic [1:0] rank, input logic wr);
        issue_valid = 1'b1;
        issue_rank  = rank;
        issue_is_wr = wr;
        tick();
        issue_valid = 1'b0;
    endtask

    // Drain exp_q, one entry per cycle, starting at the current cycle.
    task automatic drain_masks(input string name);
        int cyc;
        cyc = 1;
        while (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            compared++;
            if ({turnaround_free, rd_free, wr_free} !== exp_v) begin
                mismatched++;
                $display("FAIL %s cycle %0d: free/rd/wr got %b/%h/%h want %b/%h/%h",
                         name, cyc, turnaround_free, rd_free, wr_free,
                         exp_v[8], exp_v[7:4], exp_v[3:0]);
            end
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            compared++;
            if ({turnaround_free, rd_free, wr_free, protocol_err} !== 10'b1_1111_1111_0 ||
                dbg_state !== TS_IDLE) begin
                mismatched++;
                $display("FAIL reset_idle cycle %0d: free=%b rd=%h wr=%h err=%b st=%0d want 1/f/f/0/0",
                         i, turnaround_free, rd_free, wr_free, protocol_err, dbg_state);
            end
            tick();
        end
    endtask

    task automatic push_read_r0_table();
        exp_q.push_back(9'h010);
        exp_q.push_back(9'h0F0);
        exp_q.push_back(9'h0F0);
        exp_q.push_back(9'h1FF);
    endtask

    task automatic test_read_turnaround();
        do_reset();
        push_read_r0_table();
        issue_cmd(2'd0, 1'b0);
        compared++;
        if (dbg_state !== TS_LAST_RD) begin
            mismatched++;
            $display("FAIL read_state: got %0d want %0d", dbg_state, TS_LAST_RD);
        end
        drain_masks("read_r0");
    endtask

    task automatic test_write_turnaround();
        do_reset();
        exp_q.push_back(9'h004);
        for (int i = 0; i < 4; i++) exp_q.push_back(9'h0BF);
        exp_q.push_back(9'h1FF);
        issue_cmd(2'd2, 1'b1);
        compared++;
        if (dbg_state !== TS_LAST_WR) begin
            mismatched++;
            $display("FAIL write_state: got %0d want %0d", dbg_state, TS_LAST_WR);
        end
        drain_masks("write_r2");
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue_cmd(2'd1, 1'b0);
        issue_cmd(2'd1, 1'b0);
        ticks(4);
        issue_cmd(2'd2, 1'b1);
        issue_cmd(2'd2, 1'b1);
        tick();
        compared++;
        if (protocol_err !== 1'b0 || dbg_state !== TS_LAST_WR) begin
            mismatched++;
            $display("FAIL back_to_back: err=%b st=%0d want 0/%0d",
                     protocol_err, dbg_state, TS_LAST_WR);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        issue_cmd(2'd0, 1'b1);        // W r0 at 0
        ticks(5);
        issue_cmd(2'd0, 1'b0);        // R r0 at 6 = N+tWTR, legal
        compared++;
        if (protocol_err !== 1'b0) begin
            mismatched++;
            $display("FAIL wtr_edge_legal: err=%b want 0", protocol_err);
        end
        ticks(3);
        issue_cmd(2'd0, 1'b1);        // W r0 at 10 = 6+tRTW, legal
        compared++;
        if (protocol_err !== 1'b0) begin
            mismatched++;
            $display("FAIL rtw_edge_legal: err=%b want 0", protocol_err);
        end
        tick();
        issue_cmd(2'd1, 1'b1);        // W r1 at 12 = 10+tRTRS, legal
        compared++;
        if (protocol_err !== 1'b0) begin
            mismatched++;
            $display("FAIL rtrs_edge_legal: err=%b want 0", protocol_err);
        end
        ticks(4);
        issue_cmd(2'd1, 1'b0);        // R r1 at 17 = 12+tWTR-1, illegal
        compared++;
        if (protocol_err !== 1'b1) begin
            mismatched++;
            $display("FAIL wtr_edge_illegal: err=%b want 1", protocol_err);
        end

        do_reset();
        issue_cmd(2'd0, 1'b0);        // R r0 at 0
        ticks(2);
        issue_cmd(2'd0, 1'b1);        // W r0 at 3 = N+tRTW-1, illegal
        compared++;
        if (protocol_err !== 1'b1) begin
            mismatched++;
            $display("FAIL rtw_edge_illegal: err=%b want 1", protocol_err);
        end
    endtask

    task automatic test_protocol_err();
        do_reset();
        issue_cmd(2'd1, 1'b0);        // R r1 at 0
        compared++;
        if (protocol_err !== 1'b0 || rd_free !== 4'h2) begin
            mismatched++;
            $display("FAIL err_pre: err=%b rd=%h want 0/2", protocol_err, rd_free);
        end
        issue_cmd(2'd3, 1'b0);        // R r3 at 1, blocked by tRTRS
        compared++;
        if (protocol_err !== 1'b1) begin
            mismatched++;
            $display("FAIL err_set: err=%b want 1", protocol_err);
        end
        ticks(10);
        compared++;
        if (protocol_err !== 1'b1 || turnaround_free !== 1'b1) begin
            mismatched++;
            $display("FAIL err_sticky: err=%b free=%b want 1/1", protocol_err, turnaround_free);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        compared++;
        if (protocol_err !== 1'b0 || {rd_free, wr_free} !== 8'hFF) begin
            mismatched++;
            $display("FAIL err_clear: err=%b rd=%h wr=%h want 0/f/f",
                     protocol_err, rd_free, wr_free);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue_cmd(2'd0, 1'b1);        // W r0 at 0
        tick();                       // cycle 2
        rst = 1'b0;
        tick();                       // cycle 3
        rst = 1'b1;
        compared++;
        if ({turnaround_free, rd_free, wr_free} !== 9'h1FF || dbg_state !== TS_IDLE ||
            protocol_err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid: free=%b rd=%h wr=%h st=%0d err=%b want 1/f/f/0/0",
                     turnaround_free, rd_free, wr_free, dbg_state, protocol_err);
        end
        push_read_r0_table();
        issue_cmd(2'd0, 1'b0);
        drain_masks("reset_mid_read_r0");
    endtask

`ifdef TURNAROUND_STATS_EN
    task automatic test_stats();
        do_reset();
        compared++;
        if (stat_rank_switch !== 16'd0 || stat_rw_switch !== 16'd0) begin
            mismatched++;
            $display("FAIL stats_reset: rank=%0d rw=%0d want 0/0", stat_rank_switch, stat_rw_switch);
        end
        issue_cmd(2'd0, 1'b0);
        ticks(7);
        issue_cmd(2'd0, 1'b0);
        ticks(7);
        issue_cmd(2'd1, 1'b1);
        ticks(7);
        issue_cmd(2'd1, 1'b0);
        compared++;
        if (stat_rank_switch !== 16'd1 || stat_rw_switch !== 16'd2) begin
            mismatched++;
            $display("FAIL stats_count: rank=%0d rw=%0d want 1/2", stat_rank_switch, stat_rw_switch);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read_turnaround();
        test_write_turnaround();
        test_back_to_back();
        test_boundary();
        test_protocol_err();
        test_reset_mid();
`ifdef TURNAROUND_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
